// File: rtl/in_fifo_push_arb.sv
// rtl/in_fifo_push_arb.sv - round-robin, burst-locked arbiter for the input FIFO push port
// Shares one push port between DMA and CPU; never pushes into a full FIFO.
module in_fifo_push_arb #(
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dma_valid,
   input  logic [DATA_W-1:0] dma_data,
   input  logic              dma_last,
   output logic              dma_ready,
   input  logic              cpu_valid,
   input  logic [DATA_W-1:0] cpu_data,
   input  logic              cpu_last,
   output logic              cpu_ready,
   input  logic              fifo_full,
   output logic              fifo_push,
   output logic [DATA_W-1:0] fifo_wdata,
   input  logic              clear_stats,
   output logic [1:0]        owner,
   output logic [CNT_W-1:0]  dma_beats,
   output logic [CNT_W-1:0]  cpu_beats,
   output logic [CNT_W-1:0]  stall_cycles
);

   // Encoding doubles as the owner code seen by software.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GNT_DMA = 2'b01,
      GNT_CPU = 2'b10
   } state_t;

   localparam logic [8:0] MAX_B = 9'(MAX_BURST);

   state_t            state, state_nxt;
   logic              last_owner, last_owner_nxt;   // 1 = CPU owned last
   logic [7:0]        beat_cnt, beat_cnt_nxt;
   logic              sel_valid, sel_last, accept, stall, burst_done;
   logic [DATA_W-1:0] sel_data;

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      dma_ready = 1'b0;
      cpu_ready = 1'b0;
      case (state)
         GNT_DMA: begin
            sel_valid = dma_valid;
            sel_last  = dma_last;
            sel_data  = dma_data;
            dma_ready = !fifo_full;
         end
         GNT_CPU: begin
            sel_valid = cpu_valid;
            sel_last  = cpu_last;
            sel_data  = cpu_data;
            cpu_ready = !fifo_full;
         end
         default: ;
      endcase
   end

   assign accept     = sel_valid & !fifo_full;
   assign stall      = sel_valid & fifo_full;
   assign burst_done = accept && (({1'b0, beat_cnt} + 9'd1) == MAX_B);
   assign fifo_push  = accept;
   assign fifo_wdata = sel_data;
   assign owner      = state;

   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      beat_cnt_nxt   = beat_cnt;
      case (state)
         IDLE: begin
            if (dma_valid && (!cpu_valid || last_owner)) begin
               state_nxt      = GNT_DMA;
               last_owner_nxt = 1'b0;
               beat_cnt_nxt   = 8'd0;
            end else if (cpu_valid) begin
               state_nxt      = GNT_CPU;
               last_owner_nxt = 1'b1;
               beat_cnt_nxt   = 8'd0;
            end
         end
         GNT_DMA, GNT_CPU: begin
            if (accept)
               beat_cnt_nxt = beat_cnt + 8'd1;
            // A full FIFO holds the grant; only withdraw, last or burst cap release it.
            if (!sel_valid || (accept && (sel_last || burst_done)))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         beat_cnt   <= 8'd0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         beat_cnt   <= beat_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dma_beats    <= '0;
         cpu_beats    <= '0;
         stall_cycles <= '0;
      end else if (clear_stats) begin
         dma_beats    <= '0;
         cpu_beats    <= '0;
         stall_cycles <= '0;
      end else begin
         if (accept && state == GNT_DMA)
            dma_beats <= dma_beats + CNT_W'(1);
         if (accept && state == GNT_CPU)
            cpu_beats <= cpu_beats + CNT_W'(1);
         if (stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_in_fifo_push_arb.sv
// tb/tb_in_fifo_push_arb.sv - scoreboard bench for in_fifo_push_arb
// Directed scenarios followed by random traffic, checked against a transaction-level model.
module tb_in_fifo_push_arb;
   localparam int DATA_W = 32, MAX_BURST = 16, CNT_W = 16;

   logic clk = 1'b0, rst_n = 1'b0;
   logic dma_valid = 0, dma_last = 0, cpu_valid = 0, cpu_last = 0;
   logic fifo_full = 0, clear_stats = 0;
   logic [DATA_W-1:0] dma_data = '0, cpu_data = '0;
   logic dma_ready, cpu_ready, fifo_push;
   logic [DATA_W-1:0] fifo_wdata;
   logic [1:0] owner;
   logic [CNT_W-1:0] dma_beats, cpu_beats, stall_cycles;

   always #5 clk = ~clk;

   in_fifo_push_arb #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .dma_valid(dma_valid), .dma_data(dma_data), .dma_last(dma_last), .dma_ready(dma_ready),
      .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_last(cpu_last), .cpu_ready(cpu_ready),
      .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_wdata(fifo_wdata),
      .clear_stats(clear_stats), .owner(owner),
      .dma_beats(dma_beats), .cpu_beats(cpu_beats), .stall_cycles(stall_cycles));

   typedef struct { int cyc; int src; logic [31:0] data; } beat_t;
   beat_t sb[$];

   int tests = 0, fails = 0, cur_cyc = 0;
   int exp_owner = 0;
   bit exp_dr = 0, exp_cr = 0;
   // Model: who holds the port (0 none, 1 DMA, 2 CPU), who held it last, beats in this grant.
   int m_gnt, m_last, m_cnt;
   logic [15:0] m_dma, m_cpu, m_stall;
   // Requester sources: next payload, beats left, whether the burst ends with last.
   logic [31:0] dma_seq = 32'hA0, cpu_seq = 32'hC000_0000;
   int dma_rem = 0, cpu_rem = 0;
   bit dma_use_last = 0, cpu_use_last = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cur_cyc);
      end
   endtask

   task automatic model_reset();
      m_gnt = 0; m_last = 2; m_cnt = 0;
      m_dma = 0; m_cpu = 0; m_stall = 0;
      exp_owner = 0; exp_dr = 0; exp_cr = 0;
   endtask

   task automatic model_step();
      bit v, l, push;
      logic [31:0] d;
      cur_cyc++;
      exp_owner = m_gnt;
      exp_dr = (m_gnt == 1) && !fifo_full;
      exp_cr = (m_gnt == 2) && !fifo_full;
      if (m_gnt == 0) begin
         if (dma_valid && cpu_valid) m_gnt = (m_last == 1) ? 2 : 1;
         else if (dma_valid)         m_gnt = 1;
         else if (cpu_valid)         m_gnt = 2;
         if (m_gnt != 0) begin m_cnt = 0; m_last = m_gnt; end
      end else begin
         v = (m_gnt == 1) ? dma_valid : cpu_valid;
         l = (m_gnt == 1) ? dma_last : cpu_last;
         d = (m_gnt == 1) ? dma_data : cpu_data;
         push = v && !fifo_full;
         if (push) begin
            sb.push_back('{cur_cyc, m_gnt, d});
            m_cnt++;
            if (m_gnt == 1) begin m_dma++; dma_seq++; dma_rem--; end
            else            begin m_cpu++; cpu_seq++; cpu_rem--; end
         end
         if (v && fifo_full && m_stall != 16'hFFFF) m_stall++;
         if (!v || (push && (l || m_cnt == MAX_BURST))) m_gnt = 0;
      end
      if (clear_stats) begin m_dma = 0; m_cpu = 0; m_stall = 0; end
   endtask

   task automatic tick(input bit dv, input bit cv, input bit full, input bit clr);
      dma_valid = dv; dma_data = dma_seq; dma_last = dma_use_last && dma_rem == 1;
      cpu_valid = cv; cpu_data = cpu_seq; cpu_last = cpu_use_last && cpu_rem == 1;
      fifo_full = full; clear_stats = clr;
      model_step();
      @(posedge clk); #1;
   endtask

   task automatic check_counters(input string tag);
      chk({tag, "_dma_beats"}, 64'(dma_beats), 64'(m_dma));
      chk({tag, "_cpu_beats"}, 64'(cpu_beats), 64'(m_cpu));
      chk({tag, "_stall"}, 64'(stall_cycles), 64'(m_stall));
   endtask

   always @(negedge clk) begin
      beat_t b;
      int src;
      while (sb.size() > 0 && sb[0].cyc < cur_cyc) begin
         b = sb.pop_front();
         tests++; fails++;
         $display("FAIL missing_push: beat %0h from src %0d due in cycle %0d never pushed", b.data, b.src, b.cyc);
      end
      chk("push_while_full", 64'(fifo_push & fifo_full), 64'(0));
      chk("owner", 64'(owner), 64'(exp_owner));
      chk("dma_ready", 64'(dma_ready), 64'(exp_dr));
      chk("cpu_ready", 64'(cpu_ready), 64'(exp_cr));
      if (exp_owner == 0) chk("wdata_idle", 64'(fifo_wdata), 64'(0));
      if (fifo_push) begin
         src = dma_ready ? 1 : (cpu_ready ? 2 : 0);
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_push: data %0h src %0d, none expected", fifo_wdata, src);
         end else begin
            b = sb.pop_front();
            chk("push_cycle", 64'(cur_cyc), 64'(b.cyc));
            chk("push_src", 64'(src), 64'(b.src));
            chk("push_data", 64'(fifo_wdata), 64'(b.data));
         end
      end
   end

   initial begin
      int n;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_owner", 64'(owner), 64'(0));
      check_counters("reset");
      rst_n = 1'b1;

      // Single requester: four DMA beats ending with last.
      dma_seq = 32'hA0; dma_rem = 4; dma_use_last = 1;
      tick(1, 0, 0, 0);
      chk("single_owner", 64'(owner), 64'(1));
      repeat (4) tick(1, 0, 0, 0);
      chk("single_release", 64'(owner), 64'(0));
      chk("single_dma_beats", 64'(dma_beats), 64'(4));
      tick(0, 0, 0, 0);

      // Contention: two 40-beat bursts without last.
      tick(0, 0, 0, 1);
      dma_rem = 40; dma_use_last = 0; cpu_rem = 40; cpu_use_last = 0;
      n = 0;
      while ((dma_rem > 0 || cpu_rem > 0) && n < 300) begin
         tick(dma_rem > 0, cpu_rem > 0, 0, 0);
         n++;
      end
      chk("contention_timeout", 64'(n < 300), 64'(1));
      repeat (2) tick(0, 0, 0, 0);
      chk("contention_dma", 64'(dma_beats), 64'(40));
      chk("contention_cpu", 64'(cpu_beats), 64'(40));
      check_counters("contention");

      // Full backpressure mid CPU burst.
      tick(0, 0, 0, 1);
      cpu_rem = 20; cpu_use_last = 1;
      repeat (4) tick(0, 1, 0, 0);
      repeat (5) tick(0, 1, 1, 0);
      chk("full_hold_owner", 64'(owner), 64'(2));
      n = 0;
      while (cpu_rem > 0 && n < 60) begin tick(0, 1, 0, 0); n++; end
      tick(0, 0, 0, 0);
      chk("full_stall", 64'(stall_cycles), 64'(5));
      chk("full_cpu_beats", 64'(cpu_beats), 64'(20));
      check_counters("full");

      // Withdraw: DMA drops valid after two beats, pending CPU wins next.
      dma_rem = 10; dma_use_last = 0; cpu_rem = 3; cpu_use_last = 1;
      tick(1, 0, 0, 0);
      repeat (2) tick(1, 1, 0, 0);
      tick(0, 1, 0, 0);
      chk("withdraw_idle", 64'(owner), 64'(0));
      tick(0, 1, 0, 0);
      chk("withdraw_cpu_grant", 64'(owner), 64'(2));
      while (cpu_rem > 0 && n < 200) begin tick(0, 1, 0, 0); n++; end
      tick(0, 0, 0, 0);

      // Asynchronous reset mid DMA burst.
      dma_rem = 10;
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      dma_valid = 1; dma_data = dma_seq; fifo_full = 0; cpu_valid = 0;
      #1;
      chk("pre_reset_ready", 64'(dma_ready), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("reset_dma_ready", 64'(dma_ready), 64'(0));
      chk("reset_push", 64'(fifo_push), 64'(0));
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cpu_rem = 4; cpu_use_last = 1;
      tick(1, 1, 0, 0);
      chk("reset_first_grant", 64'(owner), 64'(1));
      n = 0;
      while ((dma_rem > 0 || cpu_rem > 0) && n < 100) begin
         tick(dma_rem > 0, cpu_rem > 0, 0, 0);
         n++;
      end
      tick(0, 0, 0, 0);

      // clear_stats coincident with a push.
      dma_rem = 3; dma_use_last = 1;
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 1);
      chk("clear_dma_beats", 64'(dma_beats), 64'(0));
      chk("clear_stall", 64'(stall_cycles), 64'(0));
      tick(1, 0, 0, 0);
      chk("clear_then_count", 64'(dma_beats), 64'(1));
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if (dma_rem == 0 && $urandom_range(0, 3) == 0) begin
            dma_rem = $urandom_range(1, 40); dma_use_last = 1'($urandom_range(0, 1));
         end
         if (cpu_rem == 0 && $urandom_range(0, 3) == 0) begin
            cpu_rem = $urandom_range(1, 40); cpu_use_last = 1'($urandom_range(0, 1));
         end
         tick(dma_rem > 0 && $urandom_range(0, 9) != 0,
              cpu_rem > 0 && $urandom_range(0, 9) != 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 49) == 0);
         if (i % 100 == 99) check_counters("random");
      end
      repeat (3) tick(0, 0, 0, 0);
      check_counters("final");
      chk("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
